prc1chan: RTL and testbench

PRC1CHAN -- requirements
Module: prc1chan

---
 rtl/prc1chan.sv | 202 ++++++++++++++++++++
 tb/tb_prc1chan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prc1chan.sv
// Single-channel pulse processor: pedestal tracking, trigger-sum output, self/master
// triggering and windowed readout of a 1024-sample circular buffer over a req/ack port.
module prc1chan (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] data,
  output logic [11:0] d2sum,
  output logic [11:0] ped,
  input  logic [11:0] zthr,
  input  logic [11:0] sthr,
  input  logic [11:0] cped,
  input  logic [15:0] prescale,
  input  logic [9:0]  winbeg,
  input  logic [9:0]  swinbeg,
  input  logic [7:0]  winlen,
  input  logic [15:0] trigger,
  output logic [15:0] dout,
  input  logic [5:0]  num,
  output logic        req,
  input  logic        ack,
  input  logic        smask,
  input  logic        tmask,
  input  logic        stmask
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HDR   = 2'd1;
  localparam logic [1:0] TOKEN = 2'd2;
  localparam logic [1:0] DATA  = 2'd3;

  logic [11:0]        data_r;
  logic [11:0]        mem [0:1023];
  logic [9:0]         wptr;
  logic signed [12:0] diff;
  logic signed [12:0] sthr_s;
  logic signed [12:0] zthr_s;

  logic [19:0] ped_sum;
  logic [19:0] ped_sum_next;
  logic [7:0]  blk_cnt;
  logic [12:0] ped_lim;
  logic [11:0] ped_add;

  logic        above;
  logic        above_r;
  logic        st_event;
  logic [15:0] pre_cnt;
  logic [15:0] pre_cnt_inc;
  logic        pre_hit;
  logic        self_req;
  logic        trig_r;
  logic        master_req;

  logic [1:0]         state;
  logic [9:0]         rd_addr;
  logic [9:0]         rd_addr_next;
  logic [11:0]        rd_data;
  logic [7:0]         word_cnt;
  logic [7:0]         len_r;
  logic [14:0]        token;
  logic [14:0]        seq_cnt;
  logic               xfer;
  logic               start_pkt;
  logic               load_sample;
  logic [9:0]         start_addr;
  logic signed [13:0] samp;
  logic [11:0]        samp_clamped;

  assign diff   = $signed({1'b0, data_r}) - $signed({1'b0, ped});
  assign sthr_s = $signed({1'b0, sthr});
  assign zthr_s = $signed({1'b0, zthr});

  // Samples well above the current pedestal contribute the pedestal itself, so pulses
  // do not drag the estimate upward.
  assign ped_lim      = {1'b0, ped} + {1'b0, zthr};
  assign ped_add      = ({1'b0, data_r} <= ped_lim) ? data_r : ped;
  assign ped_sum_next = ped_sum + {8'd0, ped_add};

  assign above       = diff > zthr_s;
  assign st_event    = above & ~above_r;
  assign pre_cnt_inc = pre_cnt + 16'd1;
  assign pre_hit     = st_event && (pre_cnt_inc == prescale);
  assign self_req    = pre_hit && !stmask && (prescale != 16'd0);
  assign master_req  = trigger[15] && !trig_r && !tmask;

  assign xfer        = req & ack;
  assign start_pkt   = (state == IDLE) && (master_req || self_req);
  assign start_addr  = master_req ? (wptr - winbeg) : (wptr - swinbeg);
  assign load_sample = xfer && (((state == TOKEN) && (len_r != 8'd0)) ||
                                ((state == DATA) && (word_cnt != len_r)));

  assign samp = $signed({2'b00, rd_data}) - $signed({2'b00, ped}) + $signed({2'b00, cped});
  assign samp_clamped = (samp < 14'sd0) ? 12'd0 :
                        (samp > 14'sd4095) ? 12'd4095 : samp[11:0];

  // rd_data always holds mem[rd_addr]; the address steps on the same edge a sample is
  // consumed so back-to-back transfers need no bubble.
  always_comb begin
    rd_addr_next = rd_addr;
    if (start_pkt) begin
      rd_addr_next = start_addr;
    end else if (load_sample) begin
      rd_addr_next = rd_addr + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem[wptr] <= data_r;
    end
    rd_data <= mem[rd_addr_next];
    rd_addr <= rd_addr_next;
    data_r  <= data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= 10'd0;
      ped     <= 12'd0;
      ped_sum <= 20'd0;
      blk_cnt <= 8'd0;
      d2sum   <= 12'd0;
      pre_cnt <= 16'd0;
      above_r <= 1'b0;
      trig_r  <= 1'b0;
    end else begin
      wptr    <= wptr + 10'd1;
      blk_cnt <= blk_cnt + 8'd1;
      if (blk_cnt == 8'hff) begin
        ped     <= ped_sum_next[19:8];
        ped_sum <= 20'd0;
      end else begin
        ped_sum <= ped_sum_next;
      end
      d2sum   <= (!smask && (diff > sthr_s)) ? diff[11:0] : 12'd0;
      above_r <= above;
      trig_r  <= trigger[15];
      if (st_event) begin
        pre_cnt <= pre_hit ? 16'd0 : pre_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      req      <= 1'b0;
      dout     <= 16'd0;
      seq_cnt  <= 15'd0;
      word_cnt <= 8'd0;
      len_r    <= 8'd0;
      token    <= 15'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pkt) begin
            state    <= HDR;
            req      <= 1'b1;
            dout     <= {1'b1, ~master_req, num, winlen};
            len_r    <= winlen;
            word_cnt <= 8'd0;
            token    <= master_req ? trigger[14:0] : (seq_cnt + 15'd1);
            if (!master_req) begin
              seq_cnt <= seq_cnt + 15'd1;
            end
          end
        end
        HDR: begin
          if (xfer) begin
            dout  <= {1'b0, token};
            state <= TOKEN;
          end
        end
        TOKEN: begin
          if (xfer) begin
            if (len_r == 8'd0) begin
              req   <= 1'b0;
              state <= IDLE;
            end else begin
              dout     <= {4'd0, samp_clamped};
              word_cnt <= 8'd1;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            if (word_cnt == len_r) begin
              req   <= 1'b0;
              state <= IDLE;
            end else begin
              dout     <= {4'd0, samp_clamped};
              word_cnt <= word_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prc1chan.sv
// Bench for prc1chan: a sample-level reference model checked every clock, plus
// hand-computed expectations for pedestal, trigger sum and packet contents.
`timescale 1ns/1ps
module tb_prc1chan;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data, zthr, sthr, cped;
  logic [15:0] prescale, trigger;
  logic [9:0]  winbeg, swinbeg;
  logic [7:0]  winlen;
  logic [5:0]  num;
  logic        ack, smask, tmask, stmask;
  logic [11:0] d2sum, ped;
  logic [15:0] dout;
  logic        req;

  always #5 clk = ~clk;

  prc1chan dut (
    .clk(clk), .reset(reset), .data(data), .d2sum(d2sum), .ped(ped),
    .zthr(zthr), .sthr(sthr), .cped(cped), .prescale(prescale),
    .winbeg(winbeg), .swinbeg(swinbeg), .winlen(winlen), .trigger(trigger),
    .dout(dout), .num(num), .req(req), .ack(ack), .smask(smask),
    .tmask(tmask), .stmask(stmask)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_buf [1024];
  int m_wptr, m_ped, m_sum, m_cnt, m_pcnt, m_seq, m_data_r, exp_d2;
  bit m_above, m_tprev;
  int expq [$];   // literal words, or 65536 + buffer address for sample words
  int rx [$];     // words actually transferred
  bit prev_req = 1'b0;
  int prev_dout = 0;
  int ack_mode = 1;
  bit last_req = 1'b0;

  int pulse   [10] = '{15, 20, 40, 100, 120, 110, 90, 50, 20, 15};
  int lit_s10 [10] = '{0, 0, 30, 90, 110, 100, 80, 40, 0, 0};
  int lit_s9  [10] = '{0, 10, 30, 90, 110, 100, 80, 40, 10, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int resolve(input int item);
    int s;
    if (item < 65536) return item;
    s = m_buf[item - 65536] - m_ped + int'(cped);
    if (s < 0) s = 0;
    if (s > 4095) s = 4095;
    return s;
  endfunction

  function automatic int rx_at(input int i);
    if (i < rx.size()) return rx[i];
    return -1;
  endfunction

  function automatic int count_hdr();
    int n = 0;
    foreach (rx[i]) if (rx[i] >= 32768) n++;
    return n;
  endfunction

  function automatic int bad_samples(input int first, input int last, input int val);
    int n = 0;
    for (int i = first; i <= last; i++) if (rx_at(i) != val) n++;
    return n;
  endfunction

  // Per-clock compare against the reference model
  initial begin : checker_proc
    int diff, acc, start, hdr, tok;
    bit above, sreq, mreq;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_wptr = 0; m_ped = 0; m_sum = 0; m_cnt = 0; m_pcnt = 0; m_seq = 0;
        m_above = 0; m_tprev = 0; exp_d2 = 0;
        expq.delete();
        chk("reset_dout", int'(dout), 0);
      end else begin
        diff   = m_data_r - m_ped;
        exp_d2 = (!smask && diff > int'(sthr)) ? diff : 0;
        acc    = (m_data_r <= m_ped + int'(zthr)) ? m_data_r : m_ped;
        above  = diff > int'(zthr);
        m_sum += acc;
        m_cnt++;
        if (m_cnt == 256) begin
          m_ped = m_sum / 256;
          m_sum = 0;
          m_cnt = 0;
        end
        sreq = 0;
        if (above && !m_above) begin
          if (((m_pcnt + 1) % 65536) == int'(prescale)) begin
            m_pcnt = 0;
            sreq = !stmask && (prescale != 0);
          end else begin
            m_pcnt = (m_pcnt + 1) % 65536;
          end
        end
        m_above = above;
        mreq = trigger[15] && !m_tprev && !tmask;
        m_tprev = trigger[15];
        if (expq.size() == 0) begin
          if (mreq || sreq) begin
            start = (((m_wptr - int'(mreq ? winbeg : swinbeg)) % 1024) + 1024) % 1024;
            if (mreq) begin
              tok = int'(trigger[14:0]);
            end else begin
              m_seq = (m_seq + 1) % 32768;
              tok = m_seq;
            end
            hdr = 32768 + (mreq ? 0 : 16384) + int'(num) * 256 + int'(winlen);
            expq.push_back(hdr);
            expq.push_back(tok);
            for (int i = 0; i < int'(winlen); i++) expq.push_back(65536 + (start + i) % 1024);
          end
        end else if (prev_req && ack) begin
          void'(expq.pop_front());
          rx.push_back(prev_dout);
        end
        m_buf[m_wptr] = m_data_r;
        m_wptr = (m_wptr + 1) % 1024;
      end
      m_data_r = int'(data);
      chk("ped", int'(ped), m_ped);
      chk("d2sum", int'(d2sum), exp_d2);
      chk("req", int'(req), int'(expq.size() != 0));
      if (expq.size() != 0) chk("dout", int'(dout), resolve(expq[0]));
      prev_req  = req;
      prev_dout = int'(dout);
    end
  end

  // One clock of stimulus: inputs change on the falling edge
  task automatic tick();
    @(negedge clk);
    case (ack_mode)
      0:       ack = 1'b0;
      1:       ack = last_req;
      default: ack = 1'($urandom_range(0, 1));
    endcase
    last_req = req;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nz, n;
    reset = 1; data = 12'd10; zthr = 12'd10; sthr = 12'd10; cped = 12'd50;
    prescale = 16'd0; trigger = 16'd0; winbeg = 10'd50; swinbeg = 10'd20;
    winlen = 8'd200; num = 6'h2A; ack = 0; smask = 0; tmask = 0; stmask = 0;
    repeat (4) tick();
    reset = 0;

    // Flat baseline settles the pedestal
    repeat (512) tick();
    chk("baseline_ped", int'(ped), 10);
    chk("baseline_d2sum", int'(d2sum), 0);

    // Trigger-sum pulse at the strict threshold and one count below it
    for (int t = 0; t < 2; t++) begin
      sthr = (t == 0) ? 12'd10 : 12'd9;
      repeat (20) tick();
      for (int j = 0; j < 12; j++) begin
        tick();
        if (j >= 2) chk(t == 0 ? "pulse_d2sum_sthr10" : "pulse_d2sum_sthr9", int'(d2sum),
                        t == 0 ? lit_s10[j-2] : lit_s9[j-2]);
        data = (j < 10) ? 12'(pulse[j]) : 12'd10;
      end
    end
    sthr = 12'd10;

    // Master trigger held two clocks, consumer acks one clock behind req
    repeat (100) tick();
    rx.delete();
    tick(); trigger = 16'h8555;
    tick(); tick(); trigger = 16'h0000;
    repeat (300) tick();
    chk("master_words", rx.size(), 202);
    chk("master_packets", count_hdr(), 1);
    chk("master_header", rx_at(0), 16'hAAC8);
    chk("master_token", rx_at(1), 16'h0555);
    chk("master_bad_samples", bad_samples(2, 201, 16'h0032), 0);
    chk("master_idle_req", int'(req), 0);

    // Masked master trigger, then masked trigger sum
    tmask = 1; rx.delete();
    tick(); trigger = 16'h8555;
    repeat (3) tick(); trigger = 16'h0000;
    repeat (20) tick();
    tmask = 0;
    chk("tmask_words", rx.size(), 0);
    smask = 1; nz = 0;
    tick();
    for (int j = 0; j < 14; j++) begin
      tick();
      if (d2sum != 0) nz++;
      data = (j < 10) ? 12'(pulse[j]) : 12'd10;
    end
    smask = 0;
    chk("smask_nonzero_d2sum", nz, 0);

    // Reset in the middle of a packet, then a fresh packet
    repeat (50) tick();
    rx.delete();
    tick(); trigger = 16'h8123;
    tick(); trigger = 16'h0000;
    n = 0;
    while (rx.size() < 52 && n < 500) begin tick(); n++; end
    chk("abort_reached_word50", rx.size(), 52);
    reset = 1;
    tick();
    chk("abort_req_low", int'(req), 0);
    reset = 0;
    repeat (300) tick();
    rx.delete();
    tick(); trigger = 16'h8321;
    tick(); trigger = 16'h0000;
    repeat (300) tick();
    chk("fresh_words", rx.size(), 202);
    chk("fresh_header", rx_at(0), 16'hAAC8);
    chk("fresh_token", rx_at(1), 16'h0321);
    chk("fresh_bad_samples", bad_samples(2, 201, 16'h0032), 0);

    // Prescaled self trigger with a randomly stalling consumer
    reset = 1; repeat (2) tick(); reset = 0;
    prescale = 16'd10; ack_mode = 2; rx.delete();
    repeat (512) tick();
    for (int p = 0; p < 30; p++) begin
      for (int j = 0; j < 10; j++) begin tick(); data = 12'(pulse[j]); end
      tick(); data = 12'd10;
      repeat (245) tick();
    end
    repeat (700) tick();
    chk("self_packets", count_hdr(), 3);
    chk("self_words", rx.size(), 606);
    for (int k = 0; k < 3; k++) begin
      chk("self_header", rx_at(k * 202), 16'hEAC8);
      chk("self_token", rx_at(k * 202 + 1), k + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
